// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush controller
// and the hazard comparator it shares with the forwarding unit.
package pipe_ctrl_pkg;

    // Controller states; the encoding is visible on state_o.
    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        MEM_WAIT = 2'd2
    } state_t;

    // Register-specifier width (32 architectural registers).
    localparam int REG_W = 5;

    // Width of the load-use and memory-wait counters.
    localparam int CNT_W = 8;

    // Saturating increment: the counters stick at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard comparator. Flags a load in ID/EX whose destination
// (other than r0) is a source of the instruction sitting in IF/ID.
// Purely combinational so it can be dropped into the forwarding unit as well.
module hazard_detect
    import pipe_ctrl_pkg::*;
(
    input  logic             i_memRead,
    input  logic [REG_W-1:0] i_exRt,
    input  logic [REG_W-1:0] i_ifRs,
    input  logic [REG_W-1:0] i_ifRt,
    output logic             o_hazard
);

    assign o_hazard = i_memRead
                    && (i_exRt != '0)
                    && ((i_exRt == i_ifRs) || (i_exRt == i_ifRt));

endmodule

// File: rtl/pipeline_ctrl.sv
// Central stall/flush controller for the five-stage pipeline.
// Handles load-use bubbles, whole-pipeline freeze during data-memory waits
// (with a sticky timeout flag) and IF/ID flush on taken branches.
// Optional build macro PIPE_CTRL_PERF_EN adds stall/flush cycle counters.
// MEM_TIMEOUT is meaningful in the range 1..255 (wait counter is 8-bit).
module pipeline_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int LU_CYCLES   = 1,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             id_ex_memread_i,
    input  logic [REG_W-1:0] id_ex_rt_i,
    input  logic [REG_W-1:0] if_id_rs_i,
    input  logic [REG_W-1:0] if_id_rt_i,
    input  logic             branch_taken_i,
    input  logic             mem_req_i,
    input  logic             mem_ack_i,
    output logic             pc_stall_o,
    output logic             if_id_stall_o,
    output logic             id_ex_stall_o,
    output logic             ex_mem_stall_o,
    output logic             if_id_flush_o,
    output logic             id_ex_bubble_o,
    output logic [1:0]       state_o,
    output logic             mem_err_o
`ifdef PIPE_CTRL_PERF_EN
   ,output logic [31:0]      stall_cnt_o,
    output logic [31:0]      flush_cnt_o
`endif
);

    localparam logic [CNT_W-1:0] LU_LAST  = CNT_W'(LU_CYCLES - 1);
    localparam logic [CNT_W-1:0] WAIT_MAX = CNT_W'(MEM_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           r_state;
    logic [CNT_W-1:0] r_waitCnt;
    logic [CNT_W-1:0] r_luCnt;
    logic             r_memErr;

    state_t           w_nextState;
    logic [CNT_W-1:0] w_nextWait;
    logic [CNT_W-1:0] w_nextLu;
    logic             w_setErr;
    logic             w_hazard;
    logic             w_memStall;
    logic             w_frontStall;
    logic             w_backStall;
    logic             w_flush;
    logic             w_bubble;

    hazard_detect u_hazard (
        .i_memRead (id_ex_memread_i),
        .i_exRt    (id_ex_rt_i),
        .i_ifRs    (if_id_rs_i),
        .i_ifRt    (if_id_rt_i),
        .o_hazard  (w_hazard)
    );

    assign w_memStall = mem_req_i & ~mem_ack_i;

    // Next-state and Mealy output decode; freeze beats load-use beats flush.
    always_comb begin
        w_nextState  = r_state;
        w_nextWait   = r_waitCnt;
        w_nextLu     = r_luCnt;
        w_setErr     = 1'b0;
        w_frontStall = 1'b0;
        w_backStall  = 1'b0;
        w_flush      = 1'b0;
        w_bubble     = 1'b0;
        case (r_state)
            RUN: begin
                if (w_memStall) begin
                    w_frontStall = 1'b1;
                    w_backStall  = 1'b1;
                    w_nextState  = MEM_WAIT;
                    w_nextWait   = CNT_ONE;
                end else if (w_hazard) begin
                    w_frontStall = 1'b1;
                    w_bubble     = 1'b1;
                    if (LU_CYCLES > 1) begin
                        w_nextState = LU_STALL;
                        w_nextLu    = CNT_ONE;
                    end
                end else if (branch_taken_i) begin
                    w_flush = 1'b1;
                end
            end
            LU_STALL: begin
                if (w_memStall) begin
                    w_frontStall = 1'b1;
                    w_backStall  = 1'b1;
                    w_nextState  = MEM_WAIT;
                    w_nextWait   = CNT_ONE;
                    w_nextLu     = '0;
                end else begin
                    w_frontStall = 1'b1;
                    w_bubble     = 1'b1;
                    if (r_luCnt >= LU_LAST) begin
                        w_nextState = RUN;
                        w_nextLu    = '0;
                    end else begin
                        w_nextLu = satInc(r_luCnt);
                    end
                end
            end
            MEM_WAIT: begin
                if (mem_ack_i) begin
                    w_nextState = RUN;
                    w_nextWait  = '0;
                end else begin
                    w_frontStall = 1'b1;
                    w_backStall  = 1'b1;
                    if (r_waitCnt == WAIT_MAX) begin
                        w_setErr    = 1'b1;
                        w_nextState = RUN;
                        w_nextWait  = '0;
                    end else begin
                        w_nextWait = satInc(r_waitCnt);
                    end
                end
            end
            default: begin
                w_nextState = RUN;
                w_nextWait  = '0;
                w_nextLu    = '0;
            end
        endcase
    end

    // State, counters and the sticky timeout flag; reset aborts any wait.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state   <= RUN;
            r_waitCnt <= '0;
            r_luCnt   <= '0;
            r_memErr  <= 1'b0;
        end else begin
            r_state   <= w_nextState;
            r_waitCnt <= w_nextWait;
            r_luCnt   <= w_nextLu;
            if (w_setErr) begin
                r_memErr <= 1'b1;
            end
        end
    end

    // While reset is held the pipeline is kept flushed and bubbled, never stalled.
    assign pc_stall_o     = ~rst_i & w_frontStall;
    assign if_id_stall_o  = ~rst_i & w_frontStall;
    assign id_ex_stall_o  = ~rst_i & w_backStall;
    assign ex_mem_stall_o = ~rst_i & w_backStall;
    assign if_id_flush_o  = rst_i | w_flush;
    assign id_ex_bubble_o = rst_i | w_bubble;
    assign state_o        = rst_i ? 2'd0 : r_state;
    assign mem_err_o      = r_memErr;

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] r_stallCnt;
    logic [31:0] r_flushCnt;

    // Free-running performance counters, wrapping modulo 2^32.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_stallCnt <= '0;
            r_flushCnt <= '0;
        end else begin
            if (pc_stall_o) begin
                r_stallCnt <= r_stallCnt + 32'd1;
            end
            if (if_id_flush_o) begin
                r_flushCnt <= r_flushCnt + 32'd1;
            end
        end
    end

    assign stall_cnt_o = r_stallCnt;
    assign flush_cnt_o = r_flushCnt;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed testbench for pipeline_ctrl. Two instances share the stimulus:
// lu1 uses LU_CYCLES=1, lu2 uses LU_CYCLES=2; both use MEM_TIMEOUT=4.
// Observed outputs are packed as {state[1:0], mem_err, pc, if_id, id_ex,
// ex_mem stall, flush, bubble}.
module tb_pipeline_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       memRead;
    logic [4:0] exRt;
    logic [4:0] ifRs;
    logic [4:0] ifRt;
    logic       branch;
    logic       memReq;
    logic       memAck;

    logic       pcStall1, ifIdStall1, idExStall1, exMemStall1, flush1, bubble1, err1;
    logic [1:0] state1;
    logic       pcStall2, ifIdStall2, idExStall2, exMemStall2, flush2, bubble2, err2;
    logic [1:0] state2;
`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] stallCnt1, flushCnt1, stallCnt2, flushCnt2;
`endif

    int testCount = 0;
    int failCount = 0;

    localparam logic [5:0] NONE = 6'b000000;
    localparam logic [5:0] LUB  = 6'b110001;
    localparam logic [5:0] FRZ  = 6'b111100;
    localparam logic [5:0] FLS  = 6'b000010;
    localparam logic [5:0] RSTV = 6'b000011;

    // Free-running clock, 10 ns period.
    always #5 clk = ~clk;

    pipeline_ctrl #(.LU_CYCLES(1), .MEM_TIMEOUT(4)) dut1 (
        .clk_i           (clk),
        .rst_i           (rst),
        .id_ex_memread_i (memRead),
        .id_ex_rt_i      (exRt),
        .if_id_rs_i      (ifRs),
        .if_id_rt_i      (ifRt),
        .branch_taken_i  (branch),
        .mem_req_i       (memReq),
        .mem_ack_i       (memAck),
        .pc_stall_o      (pcStall1),
        .if_id_stall_o   (ifIdStall1),
        .id_ex_stall_o   (idExStall1),
        .ex_mem_stall_o  (exMemStall1),
        .if_id_flush_o   (flush1),
        .id_ex_bubble_o  (bubble1),
        .state_o         (state1),
        .mem_err_o       (err1)
`ifdef PIPE_CTRL_PERF_EN
       ,.stall_cnt_o     (stallCnt1),
        .flush_cnt_o     (flushCnt1)
`endif
    );

    pipeline_ctrl #(.LU_CYCLES(2), .MEM_TIMEOUT(4)) dut2 (
        .clk_i           (clk),
        .rst_i           (rst),
        .id_ex_memread_i (memRead),
        .id_ex_rt_i      (exRt),
        .if_id_rs_i      (ifRs),
        .if_id_rt_i      (ifRt),
        .branch_taken_i  (branch),
        .mem_req_i       (memReq),
        .mem_ack_i       (memAck),
        .pc_stall_o      (pcStall2),
        .if_id_stall_o   (ifIdStall2),
        .id_ex_stall_o   (idExStall2),
        .ex_mem_stall_o  (exMemStall2),
        .if_id_flush_o   (flush2),
        .id_ex_bubble_o  (bubble2),
        .state_o         (state2),
        .mem_err_o       (err2)
`ifdef PIPE_CTRL_PERF_EN
       ,.stall_cnt_o     (stallCnt2),
        .flush_cnt_o     (flushCnt2)
`endif
    );

    function automatic logic [8:0] ex(input logic [1:0] st, input logic er, input logic [5:0] o);
        return {st, er, o};
    endfunction

    function automatic logic [8:0] pack1();
        return {state1, err1, pcStall1, ifIdStall1, idExStall1, exMemStall1, flush1, bubble1};
    endfunction

    function automatic logic [8:0] pack2();
        return {state2, err2, pcStall2, ifIdStall2, idExStall2, exMemStall2, flush2, bubble2};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        testCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Drive one cycle of inputs on the falling edge, then let outputs settle.
    task automatic applyStimulus(input logic r, input logic mr, input logic [4:0] er,
                                 input logic [4:0] s, input logic [4:0] t,
                                 input logic b, input logic q, input logic a);
        @(negedge clk);
        rst     = r;
        memRead = mr;
        exRt    = er;
        ifRs    = s;
        ifRt    = t;
        branch  = b;
        memReq  = q;
        memAck  = a;
        #1;
    endtask

    task automatic stepCheck(input string tag, input logic r, input logic mr, input logic [4:0] er,
                             input logic [4:0] s, input logic [4:0] t,
                             input logic b, input logic q, input logic a,
                             input logic [8:0] exp1, input logic [8:0] exp2);
        applyStimulus(r, mr, er, s, t, b, q, a);
        checkOutput({tag, "_lu1"}, 32'(pack1()), 32'(exp1));
        checkOutput({tag, "_lu2"}, 32'(pack2()), 32'(exp2));
    endtask

    initial begin
        rst = 1'b1; memRead = 1'b0; exRt = '0; ifRs = '0; ifRt = '0;
        branch = 1'b0; memReq = 1'b0; memAck = 1'b0;

        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
        stepCheck("reset",      1, 0, 0, 0, 0, 0, 0, 0, ex(0,0,RSTV), ex(0,0,RSTV));

        // Load-use on r5 through rs: 1 bubble for lu1, 2 bubbles (state 0,1,0) for lu2.
        stepCheck("lu_r5",      0, 1, 5, 5, 0, 0, 0, 0, ex(0,0,LUB),  ex(0,0,LUB));
        stepCheck("lu_tail",    0, 0, 5, 5, 0, 0, 0, 0, ex(0,0,NONE), ex(1,0,LUB));
        stepCheck("lu_done",    0, 0, 0, 0, 0, 0, 0, 0, ex(0,0,NONE), ex(0,0,NONE));
        stepCheck("lu_r0",      0, 1, 0, 0, 0, 0, 0, 0, ex(0,0,NONE), ex(0,0,NONE));
        stepCheck("lu_rt",      0, 1, 7, 3, 7, 0, 0, 0, ex(0,0,LUB),  ex(0,0,LUB));
        stepCheck("no_memrd",   0, 0, 7, 7, 7, 0, 0, 0, ex(0,0,NONE), ex(1,0,LUB));

        // Memory access acked 3 cycles after request: 3 frozen cycles.
        stepCheck("mem_req",    0, 0, 0, 0, 0, 0, 1, 0, ex(0,0,FRZ),  ex(0,0,FRZ));
        stepCheck("mem_w1",     0, 0, 0, 0, 0, 0, 1, 0, ex(2,0,FRZ),  ex(2,0,FRZ));
        stepCheck("mem_w2",     0, 0, 0, 0, 0, 0, 1, 0, ex(2,0,FRZ),  ex(2,0,FRZ));
        stepCheck("mem_ack",    0, 0, 0, 0, 0, 0, 1, 1, ex(2,0,NONE), ex(2,0,NONE));
        stepCheck("mem_zero",   0, 0, 0, 0, 0, 0, 1, 1, ex(0,0,NONE), ex(0,0,NONE));

        // Taken branch during a 2-cycle freeze: flush only once running again.
        stepCheck("br_frz0",    0, 0, 0, 0, 0, 1, 1, 0, ex(0,0,FRZ),  ex(0,0,FRZ));
        stepCheck("br_frz1",    0, 0, 0, 0, 0, 1, 1, 0, ex(2,0,FRZ),  ex(2,0,FRZ));
        stepCheck("br_ack",     0, 0, 0, 0, 0, 1, 1, 1, ex(2,0,NONE), ex(2,0,NONE));
        stepCheck("br_flush",   0, 0, 0, 0, 0, 1, 0, 0, ex(0,0,FLS),  ex(0,0,FLS));

        // Load-use and taken branch together: bubble first, flush later.
        stepCheck("lubr_0",     0, 1, 5, 5, 0, 1, 0, 0, ex(0,0,LUB),  ex(0,0,LUB));
        stepCheck("lubr_1",     0, 0, 5, 5, 0, 1, 0, 0, ex(0,0,FLS),  ex(1,0,LUB));
        stepCheck("lubr_2",     0, 0, 5, 5, 0, 1, 0, 0, ex(0,0,FLS),  ex(0,0,FLS));

        // Memory stall arriving mid LU_STALL pre-empts the remaining bubble.
        stepCheck("lumem_0",    0, 1, 5, 5, 0, 0, 0, 0, ex(0,0,LUB),  ex(0,0,LUB));
        stepCheck("lumem_1",    0, 0, 5, 5, 0, 0, 1, 0, ex(0,0,FRZ),  ex(1,0,FRZ));
        stepCheck("lumem_ack",  0, 0, 0, 0, 0, 0, 1, 1, ex(2,0,NONE), ex(2,0,NONE));

        // Timeout with MEM_TIMEOUT=4: error after 4 wait cycles, back to RUN.
        stepCheck("to_req",     0, 0, 0, 0, 0, 0, 1, 0, ex(0,0,FRZ),  ex(0,0,FRZ));
        for (int i = 1; i <= 4; i++) begin
            stepCheck($sformatf("to_w%0d", i), 0, 0, 0, 0, 0, 0, 1, 0, ex(2,0,FRZ), ex(2,0,FRZ));
        end
        stepCheck("to_err",     0, 0, 0, 0, 0, 0, 1, 0, ex(0,1,FRZ),  ex(0,1,FRZ));

        // Reset while in MEM_WAIT: outputs forced at once, error cleared at the edge.
        stepCheck("rst_mid",    1, 0, 0, 0, 0, 0, 1, 0, ex(0,1,RSTV), ex(0,1,RSTV));
        stepCheck("rst_held",   1, 0, 0, 0, 0, 0, 0, 0, ex(0,0,RSTV), ex(0,0,RSTV));
        stepCheck("rst_rel",    0, 0, 0, 0, 0, 0, 0, 0, ex(0,0,NONE), ex(0,0,NONE));

`ifdef PIPE_CTRL_PERF_EN
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, 5, 5, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 1);
        applyStimulus(0, 1, 5, 5, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 1, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 1, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("perf_stall_lu1", stallCnt1, 32'd5);
        checkOutput("perf_flush_lu1", flushCnt1, 32'd2);
        checkOutput("perf_stall_lu2", stallCnt2, 32'd6);
        checkOutput("perf_flush_lu2", flushCnt2, 32'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central stall/flush controller for the five-stage pipeline. It detects load-use hazards between the ID/EX and IF/ID registers and freezes the whole pipeline while a data-memory access is outstanding. It also flushes IF/ID on taken branches. It drives the `stall` inputs of PC, IF/ID, ID/EX and EX/MEM, the IF/ID flush, and the ID/EX bubble (control-field clear). It sits beside the pipeline registers and contains no datapath.

## Interface
Parameters:
- `LU_CYCLES`, default 1: bubble cycles per load-use hazard, 1–3. Use 1 with forwarding, 2 without.
- `MEM_TIMEOUT`, default 255: maximum MEM_WAIT cycles before `mem_err_o` fires.

Ports:
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_i`  in  1  reset; synchronous and active-high.
- `id_ex_memread_i`  in  1  MemRead bit of ID/EX M field.
- `id_ex_rt_i`  in  5  destination register (rt) held in ID/EX.
- `if_id_rs_i`, `if_id_rt_i`  in  5 each  source registers of the instruction in IF/ID.
- `branch_taken_i`  in  1  ID-stage branch resolved taken.
- `mem_req_i`  in  1  EX/MEM issues a data-memory access this cycle.
- `mem_ack_i`  in  1  data memory completes the access.
- `pc_stall_o`, `if_id_stall_o`, `id_ex_stall_o`, `ex_mem_stall_o`  out  1 each  hold the corresponding register.
- `if_id_flush_o`  out  1  load NOP into IF/ID.
- `id_ex_bubble_o`  out  1  zero WB/M/EX fields entering ID/EX.
- `state_o`  out  2  current state: 0 RUN, 1 LU_STALL, 2 MEM_WAIT.
- `mem_err_o`  out  1  sticky timeout flag.

## Operation
- Hazard condition `hz`: `id_ex_memread_i` and `id_ex_rt_i != 0` and (`id_ex_rt_i == if_id_rs_i` or `id_ex_rt_i == if_id_rt_i`).
- The FSM is registered. Outputs are Mealy, combinational from state and inputs.
- **RUN**
  - `mem_req_i & !mem_ack_i`: assert all four stalls; go to MEM_WAIT with `wcnt` = 1.
  - Otherwise, if `hz`: assert `pc_stall_o`, `if_id_stall_o` and `id_ex_bubble_o`. If `LU_CYCLES` > 1, go to LU_STALL with `lcnt` = 1; otherwise stay in RUN.
  - Otherwise, if `branch_taken_i`: assert `if_id_flush_o`.
  - `mem_req_i & mem_ack_i` in the same cycle is a zero-wait access: no stall.
- **LU_STALL**
  - Assert `pc_stall_o`, `if_id_stall_o` and `id_ex_bubble_o`; increment `lcnt`.
  - At `lcnt == LU_CYCLES-1`, return to RUN.
  - A `mem_req_i & !mem_ack_i` here takes priority: go to MEM_WAIT and discard the remaining bubbles.
- **MEM_WAIT**
  - Assert all four stalls. No flush and no bubble.
  - On `mem_ack_i`: release the stalls in that same cycle and return to RUN.
  - Otherwise increment `wcnt`. At `wcnt == MEM_TIMEOUT`, set `mem_err_o` and return to RUN.
- Priority: memory freeze > load-use > branch flush.
  - A suppressed branch flush is not lost: IF/ID holds the branch, so `branch_taken_i` re-presents.
  - Load-use plus taken branch in the same cycle: bubble only; the flush follows on a later cycle.
- `wcnt` and `lcnt` are 8-bit and saturate; they never wrap.

## Timing
- Reset (`rst_i` high at an edge): state → RUN, counters → 0, `mem_err_o` → 0.
- While `rst_i` is high, outputs are forced to:
  - all four stalls = 0;
  - `if_id_flush_o` = 1;
  - `id_ex_bubble_o` = 1;
  - `state_o` = 0.
- Reset mid-MEM_WAIT or mid-LU_STALL aborts to RUN on that edge.
- Detection-to-stall latency: 0 cycles (combinational).
- State change takes effect at the next edge.
- A load-use hazard costs exactly `LU_CYCLES` bubbles.
- A memory access with ack N cycles after req (N ≥ 1) costs N frozen cycles.
- `mem_err_o` clears only on reset.

## Configuration
- `PIPE_CTRL_PERF_EN` defined:
  - Adds outputs `stall_cnt_o[31:0]`, counting cycles with `pc_stall_o` high.
  - Adds `flush_cnt_o[31:0]`, counting cycles with `if_id_flush_o` high outside reset.
  - Both reset to 0 and wrap modulo 2^32.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

## Structure
- `pipe_ctrl_pkg` holds:
  - the state enum (RUN=0, LU_STALL=1, MEM_WAIT=2);
  - `REG_W` = 5;
  - the counter width of 8.
- One sub-module, `hazard_detect`: purely combinational `hz` comparison. It is reused by the forwarding unit.

## Test plan
- Load to r5 in ID/EX, IF/ID rs=r5, `LU_CYCLES`=1 → exactly 1 cycle with PC/IF-ID stall and bubble, then RUN. Repeat with r0: no stall.
- `LU_CYCLES`=2 with the same hazard → 2 bubble cycles; `state_o` sequence 0,1,0.
- `mem_req_i` with ack 3 cycles later → all stalls high for 3 cycles and drop in the ack cycle; `state_o` = 2 during the wait. Req and ack in the same cycle → no stall.
- Taken branch together with a 2-cycle memory wait → no flush during the freeze; `if_id_flush_o` high in the first RUN cycle after.
- `mem_ack_i` never arrives with `MEM_TIMEOUT`=4 → `mem_err_o` rises after 4 wait cycles and the FSM returns to RUN. `rst_i` pulse → `mem_err_o`=0, flush and bubble high during reset.
- `PIPE_CTRL_PERF_EN` build: 5 stall cycles and 2 flushes → `stall_cnt_o`=5, `flush_cnt_o`=2.
